// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// Fixed-priority on a single request, round-robin when both are valid.
module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       Req_Valid,
   output logic [1:0]       Req_Ready,
   input  logic [31:0]      Req0_Rs,
   input  logic [31:0]      Req0_Rt,
   input  logic [4:0]       Req0_Shamt,
   input  logic [5:0]       Req0_Funct,
   input  logic [31:0]      Req1_Rs,
   input  logic [31:0]      Req1_Rt,
   input  logic [4:0]       Req1_Shamt,
   input  logic [5:0]       Req1_Funct,
   output logic [31:0]      Alu_Rs,
   output logic [31:0]      Alu_Rt,
   output logic [4:0]       Alu_Shamt,
   output logic [5:0]       Alu_Funct,
   input  logic [31:0]      Alu_Rd,
   input  logic             Alu_Zero,
   output logic             Rsp_Valid,
   input  logic             Rsp_Ready,
   output logic [31:0]      Rsp_Data,
   output logic             Rsp_Zero,
   output logic             Rsp_Err,
   output logic             Rsp_Id,
   output logic [CNT_W-1:0] Op_Count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [5:0] F_ADD = 6'b001001;
   localparam logic [5:0] F_SUB = 6'b001010;
   localparam logic [5:0] F_SHF = 6'b100001;
   localparam logic [5:0] F_OR  = 6'b100101;

   logic [1:0]       state_q, state_d;
   logic             prio_q, prio_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rs_q, rt_q, data_q;
   logic [4:0]       shamt_q;
   logic [5:0]       funct_q;
   logic             err_q, id_q, zero_q;

   logic             gnt_vld, gnt_id, accept, rsp_hs, alu_en;
   logic [5:0]       funct_sel;
   logic             funct_bad;

   // Contention goes to prio; a lone request wins outright.
   always_comb begin
      gnt_vld   = |Req_Valid;
      gnt_id    = (&Req_Valid) ? prio_q : Req_Valid[1];
      accept    = (state_q == IDLE) && gnt_vld;
      rsp_hs    = (state_q == RESP) && Rsp_Ready;
      funct_sel = gnt_id ? Req1_Funct : Req0_Funct;
      funct_bad = !(funct_sel inside {F_ADD, F_SUB, F_SHF, F_OR});
      Req_Ready = 2'b00;
      if (accept) Req_Ready = gnt_id ? 2'b10 : 2'b01;
   end

   // Errored ops never reach the ALU, so its bus stays idle.
   always_comb begin
      alu_en    = (state_q == EXEC) && !err_q;
      Alu_Rs    = alu_en ? rs_q    : '0;
      Alu_Rt    = alu_en ? rt_q    : '0;
      Alu_Shamt = alu_en ? shamt_q : '0;
      Alu_Funct = alu_en ? funct_q : '0;
   end

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP: begin
            if (Rsp_Ready) begin
               state_d = IDLE;
               prio_d  = ~id_q;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         shamt_q <= '0;
         funct_q <= '0;
         err_q   <= 1'b0;
         id_q    <= 1'b0;
         data_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            rs_q    <= gnt_id ? Req1_Rs    : Req0_Rs;
            rt_q    <= gnt_id ? Req1_Rt    : Req0_Rt;
            shamt_q <= gnt_id ? Req1_Shamt : Req0_Shamt;
            funct_q <= funct_sel;
            err_q   <= funct_bad;
            id_q    <= gnt_id;
         end
         if (state_q == EXEC) begin
            data_q <= err_q ? 32'd0 : Alu_Rd;
            zero_q <= err_q ? 1'b1  : Alu_Zero;
         end
      end
   end

   assign Rsp_Valid = (state_q == RESP);
   assign Rsp_Data  = data_q;
   assign Rsp_Zero  = zero_q;
   assign Rsp_Err   = err_q;
   assign Rsp_Id    = id_q;
   assign Op_Count  = cnt_q;

   logic unused_rsp_hs;
   assign unused_rsp_hs = rsp_hs;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a second instance with CNT_W=2
// shares all stimulus and is used to observe counter wrap.
module tb_alu_arbiter;

   localparam logic [5:0] F_ADD = 6'b001001;
   localparam logic [5:0] F_SUB = 6'b001010;
   localparam logic [5:0] F_SHF = 6'b100001;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_BAD = 6'b111111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  Req_Valid = '0;
   logic [31:0] Req0_Rs = '0, Req0_Rt = '0, Req1_Rs = '0, Req1_Rt = '0;
   logic [4:0]  Req0_Shamt = '0, Req1_Shamt = '0;
   logic [5:0]  Req0_Funct = '0, Req1_Funct = '0;
   logic        Rsp_Ready = 1'b0;

   logic [1:0]  Req_Ready, w_Req_Ready;
   logic [31:0] Alu_Rs, Alu_Rt, Alu_Rd, w_Alu_Rs, w_Alu_Rt, w_Alu_Rd;
   logic [4:0]  Alu_Shamt, w_Alu_Shamt;
   logic [5:0]  Alu_Funct, w_Alu_Funct;
   logic        Alu_Zero, w_Alu_Zero;
   logic        Rsp_Valid, Rsp_Zero, Rsp_Err, Rsp_Id;
   logic        w_Rsp_Valid, w_Rsp_Zero, w_Rsp_Err, w_Rsp_Id;
   logic [31:0] Rsp_Data, w_Rsp_Data;
   logic [15:0] Op_Count;
   logic [1:0]  w_cnt;

   int n_chk = 0;
   int n_fail = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   // Unsupported codes return a marker so an unforced result is visible.
   function automatic logic [31:0] alu_f(input logic [5:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [4:0] s);
      case (f)
         F_ADD:   return a + b;
         F_SUB:   return a - b;
         F_SHF:   return a << s;
         F_OR:    return a | b;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   assign Alu_Rd     = alu_f(Alu_Funct, Alu_Rs, Alu_Rt, Alu_Shamt);
   assign Alu_Zero   = (Alu_Rd == 32'd0);
   assign w_Alu_Rd   = alu_f(w_Alu_Funct, w_Alu_Rs, w_Alu_Rt, w_Alu_Shamt);
   assign w_Alu_Zero = (w_Alu_Rd == 32'd0);

   alu_arbiter u_dut (
      .clk(clk), .rst(rst),
      .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
      .Req0_Rs(Req0_Rs), .Req0_Rt(Req0_Rt),
      .Req0_Shamt(Req0_Shamt), .Req0_Funct(Req0_Funct),
      .Req1_Rs(Req1_Rs), .Req1_Rt(Req1_Rt),
      .Req1_Shamt(Req1_Shamt), .Req1_Funct(Req1_Funct),
      .Alu_Rs(Alu_Rs), .Alu_Rt(Alu_Rt),
      .Alu_Shamt(Alu_Shamt), .Alu_Funct(Alu_Funct),
      .Alu_Rd(Alu_Rd), .Alu_Zero(Alu_Zero),
      .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
      .Rsp_Data(Rsp_Data), .Rsp_Zero(Rsp_Zero),
      .Rsp_Err(Rsp_Err), .Rsp_Id(Rsp_Id),
      .Op_Count(Op_Count)
   );

   alu_arbiter #(.CNT_W(2)) u_w2 (
      .clk(clk), .rst(rst),
      .Req_Valid(Req_Valid), .Req_Ready(w_Req_Ready),
      .Req0_Rs(Req0_Rs), .Req0_Rt(Req0_Rt),
      .Req0_Shamt(Req0_Shamt), .Req0_Funct(Req0_Funct),
      .Req1_Rs(Req1_Rs), .Req1_Rt(Req1_Rt),
      .Req1_Shamt(Req1_Shamt), .Req1_Funct(Req1_Funct),
      .Alu_Rs(w_Alu_Rs), .Alu_Rt(w_Alu_Rt),
      .Alu_Shamt(w_Alu_Shamt), .Alu_Funct(w_Alu_Funct),
      .Alu_Rd(w_Alu_Rd), .Alu_Zero(w_Alu_Zero),
      .Rsp_Valid(w_Rsp_Valid), .Rsp_Ready(Rsp_Ready),
      .Rsp_Data(w_Rsp_Data), .Rsp_Zero(w_Rsp_Zero),
      .Rsp_Err(w_Rsp_Err), .Rsp_Id(w_Rsp_Id),
      .Op_Count(w_cnt)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (Rsp_Valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_valid got %0b want 0", Rsp_Valid);
      end
      n_chk++;
      if (Op_Count !== 16'd0 || w_cnt !== 2'd0) begin
         n_fail++; $display("FAIL rst_cnt got %0d/%0d want 0", Op_Count, w_cnt);
      end
      n_chk++;
      if (Req_Ready !== 2'b00) begin
         n_fail++; $display("FAIL rst_ready got %b want 00", Req_Ready);
      end
      n_chk++;
      if ({Alu_Funct, Alu_Rs, Rsp_Data, Rsp_Err, Rsp_Zero, Rsp_Id} !== '0) begin
         n_fail++; $display("FAIL rst_outs got f=%h rs=%h d=%h want 0", Alu_Funct, Alu_Rs, Rsp_Data);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      Req0_Rs = 32'd5; Req0_Rt = 32'd7; Req0_Funct = F_ADD;
      Req_Valid = 2'b01; Rsp_Ready = 1'b1;
      #1;
      n_chk++;
      if (Req_Ready !== 2'b01) begin
         n_fail++; $display("FAIL add_ready got %b want 01", Req_Ready);
      end
      step();
      Req_Valid = 2'b00; Req0_Rs = 32'd100; Req0_Funct = F_SUB;
      #1;
      n_chk++;
      if (Rsp_Valid !== 1'b0 || Req_Ready !== 2'b00) begin
         n_fail++; $display("FAIL add_exec got v=%0b r=%b want 0/00", Rsp_Valid, Req_Ready);
      end
      n_chk++;
      if (Alu_Funct !== F_ADD || Alu_Rs !== 32'd5 || Alu_Rt !== 32'd7) begin
         n_fail++; $display("FAIL add_alu got f=%h rs=%0d rt=%0d want 09/5/7", Alu_Funct, Alu_Rs, Alu_Rt);
      end
      step();
      n_chk++;
      if (Rsp_Valid !== 1'b1 || Rsp_Data !== 32'd12) begin
         n_fail++; $display("FAIL add_rsp got v=%0b d=%0d want 1/12", Rsp_Valid, Rsp_Data);
      end
      n_chk++;
      if (Rsp_Zero !== 1'b0 || Rsp_Err !== 1'b0 || Rsp_Id !== 1'b0) begin
         n_fail++; $display("FAIL add_flags got z=%0b e=%0b id=%0b want 0/0/0", Rsp_Zero, Rsp_Err, Rsp_Id);
      end
      n_chk++;
      if (Alu_Funct !== 6'd0) begin
         n_fail++; $display("FAIL add_alu_idle got %h want 00", Alu_Funct);
      end
      step();
      exp_cnt++;
      n_chk++;
      if (Rsp_Valid !== 1'b0 || Op_Count !== 16'(exp_cnt) || w_cnt !== 2'(exp_cnt)) begin
         n_fail++; $display("FAIL add_cnt got v=%0b c=%0d want 0/%0d", Rsp_Valid, Op_Count, exp_cnt);
      end
   endtask

   task automatic test_sub_stall();
      Req1_Rs = 32'd9; Req1_Rt = 32'd9; Req1_Funct = F_SUB;
      Req_Valid = 2'b10; Rsp_Ready = 1'b0;
      #1;
      n_chk++;
      if (Req_Ready !== 2'b10) begin
         n_fail++; $display("FAIL sub_ready got %b want 10", Req_Ready);
      end
      step();
      Req_Valid = 2'b00; Req1_Rt = 32'd1;
      step();
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (Rsp_Valid !== 1'b1 || Rsp_Data !== 32'd0 || Rsp_Zero !== 1'b1 || Rsp_Id !== 1'b1) begin
            n_fail++; $display("FAIL sub_stall%0d got v=%0b d=%0d z=%0b id=%0b want 1/0/1/1", i, Rsp_Valid, Rsp_Data, Rsp_Zero, Rsp_Id);
         end
         n_chk++;
         if (Op_Count !== 16'(exp_cnt)) begin
            n_fail++; $display("FAIL sub_stall_cnt got %0d want %0d", Op_Count, exp_cnt);
         end
         step();
      end
      Rsp_Ready = 1'b1;
      step();
      exp_cnt++;
      n_chk++;
      if (Rsp_Valid !== 1'b0 || Op_Count !== 16'(exp_cnt)) begin
         n_fail++; $display("FAIL sub_done got v=%0b c=%0d want 0/%0d", Rsp_Valid, Op_Count, exp_cnt);
      end
      step();
      n_chk++;
      if (Op_Count !== 16'(exp_cnt) || w_cnt !== 2'(exp_cnt)) begin
         n_fail++; $display("FAIL idle_ready_ign got %0d want %0d", Op_Count, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  exp_rdy;
      logic [31:0] exp_d;
      Req0_Rs = 32'd1; Req0_Rt = 32'd0; Req0_Shamt = 5'd4; Req0_Funct = F_SHF;
      Req1_Rs = 32'hF0; Req1_Rt = 32'h0F; Req1_Shamt = 5'd0; Req1_Funct = F_OR;
      Req_Valid = 2'b11; Rsp_Ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_rdy = (k % 2 == 1) ? 2'b10 : 2'b01;
         exp_d   = (k % 2 == 1) ? 32'd255 : 32'd16;
         #1;
         n_chk++;
         if (Req_Ready !== exp_rdy) begin
            n_fail++; $display("FAIL b2b_grant%0d got %b want %b", k, Req_Ready, exp_rdy);
         end
         step();
         n_chk++;
         if (Req_Ready !== 2'b00) begin
            n_fail++; $display("FAIL b2b_exec_ready%0d got %b want 00", k, Req_Ready);
         end
         step();
         n_chk++;
         if (Rsp_Valid !== 1'b1 || Rsp_Data !== exp_d || Rsp_Id !== exp_rdy[1] || Req_Ready !== 2'b00) begin
            n_fail++; $display("FAIL b2b_rsp%0d got v=%0b d=%0d id=%0b want 1/%0d/%0b", k, Rsp_Valid, Rsp_Data, Rsp_Id, exp_d, exp_rdy[1]);
         end
         step();
         exp_cnt++;
      end
      Req_Valid = 2'b00;
      n_chk++;
      if (Op_Count !== 16'(exp_cnt) || w_cnt !== 2'(exp_cnt)) begin
         n_fail++; $display("FAIL b2b_cnt got %0d/%0d want %0d", Op_Count, w_cnt, exp_cnt);
      end
   endtask

   task automatic test_err();
      Req0_Rs = 32'd3; Req0_Rt = 32'd4; Req0_Funct = F_BAD;
      Req_Valid = 2'b01; Rsp_Ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_chk++;
         if (Alu_Funct !== 6'd0 || Alu_Rs !== 32'd0) begin
            n_fail++; $display("FAIL err_alu%0d got f=%h rs=%h want 0", c, Alu_Funct, Alu_Rs);
         end
         step();
         Req_Valid = 2'b00;
      end
      n_chk++;
      if (Rsp_Valid !== 1'b1 || Rsp_Err !== 1'b1 || Rsp_Data !== 32'd0 || Rsp_Zero !== 1'b1) begin
         n_fail++; $display("FAIL err_rsp got v=%0b e=%0b d=%h z=%0b want 1/1/0/1", Rsp_Valid, Rsp_Err, Rsp_Data, Rsp_Zero);
      end
      Rsp_Ready = 1'b1;
      step();
      exp_cnt++;
      n_chk++;
      if (Op_Count !== 16'(exp_cnt)) begin
         n_fail++; $display("FAIL err_cnt got %0d want %0d", Op_Count, exp_cnt);
      end
   endtask

   task automatic test_rst_resp();
      Req0_Rs = 32'd5; Req0_Rt = 32'd7; Req0_Funct = F_ADD;
      Req1_Funct = F_ADD;
      Req_Valid = 2'b01; Rsp_Ready = 1'b0;
      step();
      Req_Valid = 2'b00;
      step();
      n_chk++;
      if (Rsp_Valid !== 1'b1 || Rsp_Data !== 32'd12) begin
         n_fail++; $display("FAIL rstr_pre got v=%0b d=%0d want 1/12", Rsp_Valid, Rsp_Data);
      end
      rst = 1'b1;
      #1;
      exp_cnt = 0;
      n_chk++;
      if (Rsp_Valid !== 1'b0 || Op_Count !== 16'd0 || Rsp_Data !== 32'd0) begin
         n_fail++; $display("FAIL rstr_now got v=%0b c=%0d d=%0d want 0/0/0", Rsp_Valid, Op_Count, Rsp_Data);
      end
      @(negedge clk);
      rst = 1'b0;
      Req_Valid = 2'b11;
      #1;
      n_chk++;
      if (Req_Ready !== 2'b01) begin
         n_fail++; $display("FAIL rstr_grant got %b want 01", Req_Ready);
      end
      Req_Valid = 2'b00;
      step();
      n_chk++;
      if (Alu_Funct !== 6'd0 || Rsp_Valid !== 1'b0 || Op_Count !== 16'd0) begin
         n_fail++; $display("FAIL cancel got f=%h v=%0b c=%0d want 0/0/0", Alu_Funct, Rsp_Valid, Op_Count);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] seq [5];
      seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      Req1_Rs = 32'd1; Req1_Rt = 32'd2; Req1_Funct = F_OR;
      Rsp_Ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         Req_Valid = 2'b10;
         step();
         Req_Valid = 2'b00;
         step();
         n_chk++;
         if (w_Rsp_Data !== 32'd3 || w_Rsp_Id !== 1'b1) begin
            n_fail++; $display("FAIL wrap_data%0d got %0d want 3", k, w_Rsp_Data);
         end
         step();
         exp_cnt++;
         n_chk++;
         if (w_cnt !== seq[k] || Op_Count !== 16'(exp_cnt)) begin
            n_fail++; $display("FAIL wrap_cnt%0d got %0d/%0d want %0d/%0d", k, w_cnt, Op_Count, seq[k], exp_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_stall();
      test_back_to_back();
      test_err();
      test_rst_resp();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
